// File: rtl/spart_rx_frontend.sv
// SPART UART receive front end: recovers 8N1 frames from the asynchronous RX
// pin and emits one-cycle write / framing-error / overrun strobes.
`timescale 1ns/1ps
module spart_rx_frontend #(
  parameter int DIV_W   = 13,
  parameter int MIN_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx_q_full,
  output logic [7:0]       rx_data,
  output logic             rx_wr,
  output logic             framing_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s2_q;
  logic             rxs;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_wr_q, rx_wr_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             sample;

  assign rxs     = rx_s2_q;
  assign div_eff = (baud_div < MIN_DIV_W) ? MIN_DIV_W : baud_div;
  assign sample  = (cnt_q == '0);

  // Synchronizer resets high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rxs) state_d = S_START;
      S_START:   if (sample) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:    if (sample && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:    if (sample) state_d = rxs ? S_IDLE : S_WAIT_HI;
      S_WAIT_HI: if (rxs) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = sample ? (div_l_q - ONE_W) : (cnt_q - ONE_W);
    div_l_d       = div_l_q;
    bit_idx_d     = bit_idx_q;
    sh_d          = sh_q;
    rx_data_d     = rx_data_q;
    rx_wr_d       = 1'b0;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;
    busy_d        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // Half-bit first count puts every later sample mid-bit.
        if (!rxs) begin
          cnt_d   = div_eff >> 1;
          div_l_d = div_eff;
        end
      end
      S_START: begin
        if (sample && !rxs) bit_idx_d = 3'd0;
      end
      S_DATA: begin
        if (sample) begin
          sh_d      = {rxs, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rxs) begin
            rx_data_d = sh_q;
            if (rx_q_full) overrun_d = 1'b1;
            else           rx_wr_d   = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l_q       <= '0;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      sh_q          <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_wr_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      div_l_q       <= div_l_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      sh_q          <= sh_d;
      rx_data_q     <= rx_data_d;
      rx_wr_q       <= rx_wr_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_wr       = rx_wr_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule
